// File: rtl/pair_triple_scheduler.sv
// Loads a hand of HAND symbols, scans all index pairs one compare per cycle,
// then reports the symbol with the most later duplicates (earliest index wins ties).
module pair_triple_scheduler #(
    parameter int SYM_W = 4,
    parameter int HAND  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SYM_W-1:0] in_data,
    input  logic             flush,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [2:0]       res_cnt,
    output logic [SYM_W-1:0] res_val,
    output logic             has_pair,
    output logic             has_triple
);

    typedef enum logic [1:0] {LOAD, SCAN, REPORT} state_t;

    localparam logic [2:0] LAST   = 3'(HAND - 1);
    localparam logic [2:0] PENULT = 3'(HAND - 2);

    state_t           state_q;
    logic [2:0]       k_q;
    logic [2:0]       i_q;
    logic [2:0]       j_q;
    logic [2:0]       cnt_q;
    logic [2:0]       best_cnt_q;
    logic [SYM_W-1:0] best_val_q;
    logic [SYM_W-1:0] slot_q [HAND];

    logic             load_fire;
    logic [HAND-1:0]  slot_we;
    logic             match;
    logic [2:0]       cnt_d;

    assign load_fire = (state_q == LOAD) && in_valid && !flush && !rst;

    genvar gi;
    generate
        for (gi = 0; gi < HAND; gi++) begin : g_slot
            assign slot_we[gi] = load_fire && (k_q == 3'(gi));

            always_ff @(posedge clk) begin
                if (slot_we[gi]) begin
                    slot_q[gi] <= in_data;
                end
            end
        end
    endgenerate

    // Count including the current compare, saturating so it can never wrap.
    assign match = (slot_q[i_q] == slot_q[j_q]);
    assign cnt_d = (cnt_q == 3'd7) ? cnt_q : cnt_q + {2'b00, match};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= LOAD;
            k_q        <= '0;
            i_q        <= '0;
            j_q        <= '0;
            cnt_q      <= '0;
            best_cnt_q <= '0;
            best_val_q <= '0;
        end else if (flush) begin
            state_q <= LOAD;
            k_q     <= '0;
        end else begin
            case (state_q)
                LOAD: begin
                    if (in_valid) begin
                        if (k_q == LAST) begin
                            state_q    <= SCAN;
                            k_q        <= '0;
                            i_q        <= 3'd0;
                            j_q        <= 3'd1;
                            cnt_q      <= '0;
                            best_cnt_q <= '0;
                            best_val_q <= '0;
                        end else begin
                            k_q <= k_q + 3'd1;
                        end
                    end
                end
                SCAN: begin
                    if (j_q == LAST) begin
                        // Strict compare keeps the earliest index on a tie.
                        if (cnt_d > best_cnt_q) begin
                            best_cnt_q <= cnt_d;
                            best_val_q <= slot_q[i_q];
                        end
                        cnt_q <= '0;
                        if (i_q == PENULT) begin
                            state_q <= REPORT;
                        end else begin
                            i_q <= i_q + 3'd1;
                            j_q <= i_q + 3'd2;
                        end
                    end else begin
                        j_q   <= j_q + 3'd1;
                        cnt_q <= cnt_d;
                    end
                end
                REPORT: begin
                    if (res_ready) begin
                        state_q <= LOAD;
                        k_q     <= '0;
                    end
                end
                default: state_q <= LOAD;
            endcase
        end
    end

    // Outputs are forced low while reset is held, independent of state.
    assign in_ready   = (state_q == LOAD) && !rst;
    assign res_valid  = (state_q == REPORT) && !rst;
    assign res_cnt    = res_valid ? best_cnt_q : 3'd0;
    assign res_val    = res_valid ? best_val_q : '0;
    assign has_pair   = (res_cnt >= 3'd1);
    assign has_triple = (res_cnt >= 3'd2);

endmodule

// File: tb/tb_pair_triple_scheduler.sv
// Self-checking bench for pair_triple_scheduler: directed hands, backpressure,
// flush, reset mid-scan and randomized hands checked against an occurrence-count model.
module tb_pair_triple_scheduler;

    localparam int SYM_W = 4;
    localparam int HAND  = 5;
    localparam int SCAN_CYCLES = HAND * (HAND - 1) / 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [SYM_W-1:0] in_data;
    logic             flush;
    logic             res_valid;
    logic             res_ready;
    logic [2:0]       res_cnt;
    logic [SYM_W-1:0] res_val;
    logic             has_pair;
    logic             has_triple;

    int checks   = 0;
    int failures = 0;
    logic [SYM_W-1:0] hand [HAND];

    always #5 clk = ~clk;

    pair_triple_scheduler #(.SYM_W(SYM_W), .HAND(HAND)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .flush     (flush),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_cnt   (res_cnt),
        .res_val   (res_val),
        .has_pair  (has_pair),
        .has_triple(has_triple)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Later-duplicate count of a symbol's first occurrence is its total
    // occurrence count minus one; earliest position wins ties.
    function automatic void model(output int bc, output int bv);
        int occ [16];
        foreach (occ[v]) occ[v] = 0;
        for (int n = 0; n < HAND; n++) occ[hand[n]]++;
        bc = 0;
        bv = 0;
        for (int n = 0; n < HAND; n++) begin
            if (occ[hand[n]] - 1 > bc) begin
                bc = occ[hand[n]] - 1;
                bv = int'(hand[n]);
            end
        end
    endfunction

    task automatic set_hand(input int a, input int b, input int c, input int d, input int e);
        hand[0] = 4'(a); hand[1] = 4'(b); hand[2] = 4'(c); hand[3] = 4'(d); hand[4] = 4'(e);
    endtask

    task automatic run_hand(input string tag, input int stall, input bit junk);
        int bc, bv, cyc;
        for (int n = 0; n < HAND; n++) begin
            in_valid = 1'b1;
            in_data  = hand[n];
            checks++;
            if (in_ready !== 1'b1) begin
                failures++;
                $display("FAIL %s load_ready sym=%0d got=%b exp=1", tag, n, in_ready);
            end
            tick;
        end
        in_valid = junk;
        in_data  = 4'($urandom);
        cyc = 0;
        while (res_valid !== 1'b1 && cyc < 40) begin
            checks++;
            if (in_ready !== 1'b0) begin
                failures++;
                $display("FAIL %s scan_ready cyc=%0d got=%b exp=0", tag, cyc, in_ready);
            end
            tick;
            cyc++;
        end
        checks++;
        if (cyc != SCAN_CYCLES) begin
            failures++;
            $display("FAIL %s latency got=%0d exp=%0d", tag, cyc, SCAN_CYCLES);
        end
        model(bc, bv);
        res_ready = 1'b0;
        for (int s = 0; s <= stall; s++) begin
            checks++;
            if (res_valid !== 1'b1 || res_cnt !== 3'(bc) || res_val !== 4'(bv) ||
                has_pair !== (bc >= 1) || has_triple !== (bc >= 2) || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL %s result s=%0d got v=%b cnt=%0d val=%0d p=%b t=%b rdy=%b exp v=1 cnt=%0d val=%0d p=%b t=%b rdy=0",
                         tag, s, res_valid, res_cnt, res_val, has_pair, has_triple, in_ready,
                         bc, bv, bc >= 1, bc >= 2);
            end
            if (s == stall) res_ready = 1'b1;
            tick;
        end
        res_ready = 1'b0;
        in_valid  = 1'b0;
        checks++;
        if (res_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s after_handshake got v=%b rdy=%b exp v=0 rdy=1", tag, res_valid, in_ready);
        end
        $display("hand %s: %0d %0d %0d %0d %0d -> cnt=%0d val=%0d stall=%0d",
                 tag, hand[0], hand[1], hand[2], hand[3], hand[4], bc, bv, stall);
    endtask

    task automatic test_reset;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 4'd5; res_ready = 1'b1;
        tick;
        tick;
        checks++;
        if (in_ready !== 1'b0 || res_valid !== 1'b0 || res_cnt !== 3'd0 || res_val !== 4'd0 ||
            has_pair !== 1'b0 || has_triple !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs got rdy=%b v=%b cnt=%0d val=%0d p=%b t=%b exp all 0",
                     in_ready, res_valid, res_cnt, res_val, has_pair, has_triple);
        end
        rst = 1'b0; in_valid = 1'b0; res_ready = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready got=%b exp=1", in_ready);
        end
    endtask

    task automatic test_directed;
        set_hand(3, 3, 3, 7, 9);  run_hand("triple", 0, 1'b0);
        set_hand(1, 2, 4, 8, 15); run_hand("none", 0, 1'b0);
        set_hand(5, 9, 5, 9, 2);  run_hand("tie", 0, 1'b1);
    endtask

    task automatic test_backpressure;
        set_hand(6, 6, 6, 6, 1);  run_hand("quad_stall", 3, 1'b0);
        set_hand(0, 0, 1, 1, 1);  run_hand("after_stall", 0, 1'b0);
    endtask

    task automatic test_flush;
        for (int n = 0; n < 3; n++) begin
            in_valid = 1'b1; in_data = 4'd2;
            tick;
        end
        flush = 1'b1; in_valid = 1'b1; in_data = 4'd2;
        tick;
        flush = 1'b0; in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || res_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_state got rdy=%b v=%b exp rdy=1 v=0", in_ready, res_valid);
        end
        set_hand(4, 1, 4, 0, 7);  run_hand("post_flush", 0, 1'b0);
    endtask

    task automatic test_reset_mid_scan;
        bit seen;
        set_hand(3, 3, 3, 7, 9);
        for (int n = 0; n < HAND; n++) begin
            in_valid = 1'b1; in_data = hand[n];
            tick;
        end
        in_valid = 1'b0;
        for (int n = 0; n < 4; n++) tick;
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0 || res_valid !== 1'b0 || res_cnt !== 3'd0 || res_val !== 4'd0 ||
            has_pair !== 1'b0 || has_triple !== 1'b0) begin
            failures++;
            $display("FAIL midscan_reset_outputs got rdy=%b v=%b cnt=%0d val=%0d p=%b t=%b exp all 0",
                     in_ready, res_valid, res_cnt, res_val, has_pair, has_triple);
        end
        tick;
        tick;
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL midscan_release_ready got=%b exp=1", in_ready);
        end
        seen = 1'b0;
        for (int n = 0; n < 15; n++) begin
            if (res_valid === 1'b1) seen = 1'b1;
            tick;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL midscan_no_result got res_valid seen=%b exp=0", seen);
        end
        set_hand(5, 9, 5, 9, 2);  run_hand("after_reset", 1, 1'b0);
    endtask

    task automatic test_random;
        for (int t = 0; t < 40; t++) begin
            for (int n = 0; n < HAND; n++) begin
                hand[n] = (t % 2 == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom);
            end
            run_hand($sformatf("rand%0d", t), int'($urandom_range(0, 3)), 1'($urandom));
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_backpressure;
        test_flush;
        test_reset_mid_scan;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pair_triple_scheduler.md
PAIR_TRIPLE_SCHEDULER -- requirements
Module: pair_triple_scheduler

Interface
REQ-001 Parameter SYM_W, default 4: width of one symbol.
REQ-002 Parameter HAND, default 5: number of symbols per hand; legal range 2..8.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-005 in_valid  input  1  symbol offered on in_data.
REQ-006 in_ready  output  1  block can accept a symbol; transfer occurs when in_valid & in_ready at a rising edge.
REQ-007 in_data  input  SYM_W  symbol value.
REQ-008 flush  input  1  discard the current hand and return to loading.
REQ-009 res_valid  output  1  result fields valid; held until accepted.
REQ-010 res_ready  input  1  consumer accepts the result when res_valid & res_ready at a rising edge.
REQ-011 res_cnt  output  3  highest count of later duplicates of any symbol (0 none, 1 pair, 2 triple, 3+ quad or more).
REQ-012 res_val  output  SYM_W  symbol with the highest count; 0 when res_cnt = 0.
REQ-013 has_pair  output  1  res_cnt >= 1.
REQ-014 has_triple  output  1  res_cnt >= 2.

Function
REQ-015 The FSM SHALL have exactly three states: LOAD, SCAN and REPORT. Reset state is LOAD.
REQ-016 In LOAD, in_ready SHALL be 1. Each transfer SHALL write in_data into slot[k], where k counts 0..HAND-1.
REQ-017 The transfer that fills slot[HAND-1] SHALL move the FSM to SCAN, set i=0 and j=1, and clear cnt and best_cnt.
REQ-018 In SCAN, in_ready SHALL be 0. The block SHALL perform one compare per cycle, slot[i] == slot[j]. On a match, cnt SHALL increment.
REQ-019 In SCAN, j SHALL advance to HAND-1. The compare of (i, HAND-1) closes index i.
REQ-020 When index i closes, if the final cnt (this compare included) is strictly greater than best_cnt, best_cnt and best_val SHALL take cnt and slot[i]. Strict compare means the earliest index wins a tie.
REQ-021 After index i closes, cnt SHALL clear, i SHALL increment and j SHALL become i+1.
REQ-022 The compare of (HAND-2, HAND-1) SHALL move the FSM to REPORT.
REQ-023 SCAN SHALL take HAND*(HAND-1)/2 cycles, which is 10 for HAND=5.
REQ-024 res_valid SHALL be high in the cycle following the edge that completes the last compare. It SHALL be 1 only in REPORT, and res_valid rises 10 cycles after the edge that accepted the last symbol.
REQ-025 In REPORT, res_cnt and res_val SHALL show best_cnt and best_val, and SHALL stay stable while res_ready = 0.
REQ-026 has_pair and has_triple SHALL decode combinationally from res_cnt.
REQ-027 In REPORT, in_ready SHALL be 0.
REQ-028 A result handshake SHALL return the FSM to LOAD with k=0. in_ready SHALL be 1 in the next cycle; no symbol is accepted in the handshake cycle.
REQ-029 flush = 1 SHALL force the FSM to LOAD with k=0 and res_valid=0 at the next edge, from any state.
REQ-030 flush SHALL take priority over an in_valid transfer in the same cycle; that symbol is discarded.
REQ-031 flush SHALL take priority over a result handshake in the same cycle.
REQ-032 res_cnt and cnt SHALL saturate at 7 and never wrap. For HAND<=8 the maximum is HAND-1.
REQ-033 in_valid outside LOAD SHALL be ignored, and in_data SHALL be ignored when no transfer occurs.

Reset
REQ-034 While rst = 1, in_ready SHALL be 0.
REQ-035 While rst = 1, res_valid, res_cnt, res_val, has_pair and has_triple SHALL be 0.
REQ-036 rst = 1 SHALL clear all counters.
REQ-037 rst = 1 SHALL set the FSM to LOAD.
REQ-038 Slot contents need not clear on reset.
REQ-039 The first cycle after rst falls SHALL show in_ready = 1.
REQ-040 rst SHALL take priority over flush and over all handshakes.
REQ-041 Reset mid-SCAN or mid-REPORT SHALL abandon the hand; no res_valid is produced for it.

Verification
REQ-042 Hand 3,3,3,7,9 with res_ready=1 -> res_valid 10 cycles after the last accept; res_cnt=2, res_val=3, has_pair=1, has_triple=1; in_ready=1 the following cycle.
REQ-043 Hand 1,2,4,8,15 -> res_cnt=0, res_val=0, has_pair=0, has_triple=0.
REQ-044 Hand 5,9,5,9,2 (tie) -> res_cnt=1, res_val=5, has_triple=0.
REQ-045 Hand 6,6,6,6,1 with res_ready=0 for 3 REPORT cycles -> res_valid and res_cnt=3, res_val=6 held stable, in_ready=0; handshake on cycle 4, then the next hand loads normally.
REQ-046 Load 2,2,2, then assert flush together with in_valid (data 2), then load 4,1,4,0,7 -> flushed symbols are discarded; result res_cnt=1, res_val=4.
REQ-047 Assert rst on SCAN cycle 5 of hand 3,3,3,7,9 -> all outputs 0, no res_valid; in_ready=1 the first cycle after release; a new hand produces a correct result.
